// File: rtl/slice_cfg_sched_pkg.sv
// Shared types and constants for the TDMA slice configuration scheduler.
package slice_cfg_sched_pkg;

  localparam int SLICE_IDX_W = 2;
  localparam int CNT_W       = 25;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_EPOCH = 2'd1,
    APPLY      = 2'd2
  } state_t;

  // 'stop' holds the window end; 'end' is a reserved word.
  typedef struct packed {
    logic [CNT_W-1:0] total;
    logic [CNT_W-1:0] start;
    logic [CNT_W-1:0] stop;
  } slice_cfg_t;

endpackage

// File: rtl/slice_shadow_table.sv
// Four-entry shadow register file with per-entry dirty bits and write validation.
module slice_shadow_table
  import slice_cfg_sched_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [SLICE_IDX_W-1:0] wr_idx,
  input  slice_cfg_t             wr_cfg,
  output logic                   wr_ok,
  input  logic                   clr_en,
  input  logic [SLICE_IDX_W-1:0] clr_idx,
  input  logic [SLICE_IDX_W-1:0] rd_idx,
  output slice_cfg_t             rd_cfg,
  output logic [3:0]             dirty
);

  slice_cfg_t tbl [4];

  assign wr_ok  = (wr_cfg.start <= wr_cfg.stop) && (wr_cfg.stop <= wr_cfg.total);
  assign rd_cfg = tbl[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) tbl[i] <= '0;
      dirty <= '0;
    end else begin
      if (clr_en) dirty[clr_idx] <= 1'b0;
      if (wr_en && wr_ok) begin
        tbl[wr_idx]   <= wr_cfg;
        dirty[wr_idx] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/slice_cfg_sched.sv
// Commits buffered slice updates to the TDMA generator on the next cycle boundary.
module slice_cfg_sched #(
  parameter int               NUM_SLICE = 4,
  parameter int               CNT_W     = 25,
  parameter int               TMO_W     = 24,
  parameter logic [TMO_W-1:0] EPOCH_TMO = 24'd10000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_wr_valid,
  output logic             cfg_wr_ready,
  input  logic [1:0]       cfg_wr_idx,
  input  logic [CNT_W-1:0] cfg_wr_total,
  input  logic [CNT_W-1:0] cfg_wr_start,
  input  logic [CNT_W-1:0] cfg_wr_end,
  input  logic             commit_req,
  input  logic             epoch_pulse,
  output logic             commit_busy,
  output logic             commit_done,
  output logic             cfg_err,
  output logic             tmo_flag,
  input  logic             err_clr,
  output logic             slv_reg_wren_signal,
  output logic [1:0]       count_total_slice_idx,
  output logic [1:0]       count_start_slice_idx,
  output logic [1:0]       count_end_slice_idx,
  output logic [CNT_W-1:0] count_total,
  output logic [CNT_W-1:0] count_start,
  output logic [CNT_W-1:0] count_end
);
  import slice_cfg_sched_pkg::*;

  localparam logic [TMO_W-1:0] TMO_LAST  = EPOCH_TMO - 1'b1;
  localparam logic [1:0]       LAST_SLOT = 2'(NUM_SLICE - 1);

  state_t               state, state_nxt;
  logic [1:0]           ptr;
  logic [TMO_W-1:0]     tmo_cnt;
  logic [NUM_SLICE-1:0] dirty;
  logic                 wr_fire, wr_ok;
  logic                 ld_en, done_nxt, tmo_set;
  logic [1:0]           ld_idx;
  slice_cfg_t           wr_cfg, ld_cfg;

  assign wr_fire = cfg_wr_valid && cfg_wr_ready;
  assign wr_cfg  = '{total: cfg_wr_total, start: cfg_wr_start, stop: cfg_wr_end};

  slice_shadow_table u_shadow (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_fire),
    .wr_idx (cfg_wr_idx),
    .wr_cfg (wr_cfg),
    .wr_ok  (wr_ok),
    .clr_en (ld_en && dirty[ld_idx]),
    .clr_idx(ld_idx),
    .rd_idx (ld_idx),
    .rd_cfg (ld_cfg),
    .dirty  (dirty)
  );

  // The slot shown in a given APPLY cycle is loaded one cycle earlier, so
  // every generator-facing output comes straight from a flop.
  always_comb begin
    state_nxt = state;
    ld_en     = 1'b0;
    ld_idx    = ptr + 2'd1;
    done_nxt  = 1'b0;
    tmo_set   = 1'b0;
    case (state)
      IDLE: begin
        if (commit_req) begin
          if ((|dirty) || (wr_fire && wr_ok)) state_nxt = WAIT_EPOCH;
          else                                done_nxt  = 1'b1;
        end
      end
      WAIT_EPOCH: begin
        if (epoch_pulse || (tmo_cnt == TMO_LAST)) begin
          state_nxt = APPLY;
          ld_en     = 1'b1;
          ld_idx    = 2'd0;
          tmo_set   = !epoch_pulse;
        end
      end
      APPLY: begin
        if (ptr == LAST_SLOT) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          ld_en = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= IDLE;
      ptr                   <= '0;
      tmo_cnt               <= '0;
      cfg_wr_ready          <= 1'b1;
      commit_busy           <= 1'b0;
      commit_done           <= 1'b0;
      cfg_err               <= 1'b0;
      tmo_flag              <= 1'b0;
      slv_reg_wren_signal   <= 1'b0;
      count_total_slice_idx <= '0;
      count_start_slice_idx <= '0;
      count_end_slice_idx   <= '0;
      count_total           <= '0;
      count_start           <= '0;
      count_end             <= '0;
    end else begin
      state        <= state_nxt;
      ptr          <= ld_en ? ld_idx : 2'd0;
      cfg_wr_ready <= (state_nxt == IDLE);
      commit_busy  <= (state_nxt != IDLE);
      commit_done  <= done_nxt;
      cfg_err      <= (wr_fire && !wr_ok) || (cfg_err && !err_clr);
      tmo_flag     <= tmo_set || (tmo_flag && !err_clr);

      if ((state == WAIT_EPOCH) && (state_nxt == WAIT_EPOCH))
        tmo_cnt <= (tmo_cnt == '1) ? tmo_cnt : tmo_cnt + 1'b1;
      else
        tmo_cnt <= '0;

      if (ld_en && dirty[ld_idx]) begin
        slv_reg_wren_signal   <= 1'b1;
        count_total_slice_idx <= ld_idx;
        count_start_slice_idx <= ld_idx;
        count_end_slice_idx   <= ld_idx;
        count_total           <= ld_cfg.total;
        count_start           <= ld_cfg.start;
        count_end             <= ld_cfg.stop;
      end else begin
        slv_reg_wren_signal   <= 1'b0;
        count_total_slice_idx <= '0;
        count_start_slice_idx <= '0;
        count_end_slice_idx   <= '0;
        count_total           <= '0;
        count_start           <= '0;
        count_end             <= '0;
      end
    end
  end

endmodule

// File: doc/slice_cfg_sched.md
Name: slice_cfg_sched

Overview:
- Software-facing configuration scheduler for the 4-slice TDMA time slice generator.
- Buffers per-slice (total, start, end) updates in a shadow table and validates each write.
- Commits only dirty entries through the generator's programming interface (wren + slice_idx + count_* buses), starting on the next TDMA cycle boundary (epoch_pulse), so slice windows never change mid-cycle.
- Falls back to a timeout commit if no boundary arrives.

Parameters:
- NUM_SLICE, 4, number of slices; fixed at 4 because the index width is 2 bits.
- CNT_W, 25, width of the total/start/end counts.
- TMO_W, 24, width of the epoch-wait timeout counter.
- EPOCH_TMO, 24'd10000000, clk cycles to wait for epoch_pulse before a forced commit.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- cfg_wr_valid  in  1  shadow write request.
- cfg_wr_ready  out  1  shadow write accepted; high only in IDLE.
- cfg_wr_idx  in  2  target slice.
- cfg_wr_total  in  CNT_W  cycle length.
- cfg_wr_start  in  CNT_W  window start.
- cfg_wr_end  in  CNT_W  window end.
- commit_req  in  1  single-cycle pulse; request to apply dirty entries.
- epoch_pulse  in  1  single-cycle TDMA cycle-boundary strobe.
- commit_busy  out  1  high in WAIT_EPOCH and APPLY.
- commit_done  out  1  single-cycle pulse at the end of a commit.
- cfg_err  out  1  sticky flag: invalid write rejected.
- tmo_flag  out  1  sticky flag: last commit was forced by timeout.
- err_clr  in  1  clears cfg_err and tmo_flag.
- slv_reg_wren_signal  out  1  generator register write strobe.
- count_total_slice_idx  out  2  slice index for count_total.
- count_start_slice_idx  out  2  slice index for count_start.
- count_end_slice_idx  out  2  slice index for count_end.
- count_total  out  CNT_W  value written to the generator.
- count_start  out  CNT_W  value written to the generator.
- count_end  out  CNT_W  value written to the generator.

Behaviour:
- Reset:
  - State IDLE.
  - Shadow table zeroed, dirty[3:0]=0, timeout counter 0.
  - All outputs 0, except cfg_wr_ready=1, which follows the state after reset.
  - Reset in any state aborts the commit with no further wren and no commit_done.
- Shadow write:
  - The handshake completes when cfg_wr_valid && cfg_wr_ready.
  - Valid when start<=end and end<=total (unsigned). The entry is updated and its dirty bit set.
  - Invalid: entry and dirty bit unchanged, cfg_err<=1. The handshake still completes.
  - Rewriting a dirty entry overwrites it (last write wins).
- cfg_err/tmo_flag:
  - err_clr clears both.
  - A set event in the same cycle as err_clr wins, leaving the flag at 1.
- IDLE:
  - commit_req with dirty==0: commit_done=1 next cycle, stay in IDLE, no wren.
  - commit_req with dirty!=0: go to WAIT_EPOCH.
  - A write accepted in the same cycle as commit_req is included in the commit.
- WAIT_EPOCH:
  - cfg_wr_ready=0. commit_req is ignored here and in APPLY.
  - An epoch_pulse coincident with the commit_req cycle is not counted.
  - The timeout counter increments each cycle.
  - epoch_pulse: go to APPLY and clear the counter.
  - Counter reaching EPOCH_TMO-1 without epoch: go to APPLY, tmo_flag<=1.
  - If epoch_pulse and timeout coincide, the epoch wins and tmo_flag is not set.
- APPLY:
  - Scan pointer runs 0,1,2,3, one slot per cycle, always exactly 4 cycles.
  - For a dirty slot: slv_reg_wren_signal=1, all three idx outputs=pointer, count_* = shadow values, dirty bit cleared.
  - Clean slot: wren=0 and idx/count outputs=0.
  - After slot 3: commit_done=1 for one cycle, return to IDLE.
- Latency:
  - epoch_pulse in cycle T: slot writes in T+1..T+4, commit_done in T+5, cfg_wr_ready=1 in T+5.
  - Registered outputs, glitch-free.
- Counter widths: all comparisons are CNT_W unsigned. The timeout counter saturates and never wraps.

Decomposition:
- Shared package holds:
  - SLICE_IDX_W=2 and CNT_W=25 constants.
  - State encoding: IDLE=2'd0, WAIT_EPOCH=2'd1, APPLY=2'd2.
  - Slice config struct {total, start, end}.
- One natural sub-module, slice_shadow_table:
  - 4-entry register file with dirty bits, the validation compare, and clear-on-apply.
  - The FSM, timeout and output registers stay in the top.

Test Plan:
- Reset, then write idx1 (total 1000, start 100, end 200), commit_req, epoch at T -> wren only at T+2 with idx=1/1000/100/200, commit_done at T+5, dirty=0.
- Write all four slots, commit, epoch -> wren high T+1..T+4 with idx 0,1,2,3 ascending. cfg_wr_valid held during busy is not accepted until T+5.
- Write idx2 with start 300, end 200 -> cfg_err=1, no dirty bit. Commit_req gives commit_done next cycle with no wren. err_clr -> cfg_err=0.
- Dirty entry, commit, no epoch for 10 cycles with EPOCH_TMO=10 -> APPLY is forced at cycle 10 and tmo_flag=1. Repeat with epoch and timeout coincident -> tmo_flag stays 0.
- Assert rst during APPLY after the slot-1 write -> wren=0 next cycle, no commit_done, all dirty bits cleared, state IDLE.
- epoch_pulse in the same cycle as commit_req -> ignored. The next epoch, 50 cycles later, triggers APPLY.
